// File: rtl/rv_decode_pkg.sv
// Shared decode types: opcodes, ALU codes,
// immediate formats and the ID->EX bundle.
package rv_decode_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_PASS_B = 5'd10,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    alu_op_e    alu_op;
    logic       is_word;
    logic       reg_write_enable;
    logic       mem_read;
    logic       mem_write;
    logic       is_branch;
    logic       jump;
    logic       alu_src_imm;
    logic       alu_src_pc;
    logic       illegal;
  } id_ex_t;

  // alt selects SUB/SRA (instr[30])
  function automatic alu_op_e base_alu(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_op_e r;
    case (f3)
      3'b000:  r = alt ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  // M-extension ops are laid out by funct3
  function automatic alu_op_e m_alu(
    input logic [2:0] f3
  );
    return alu_op_e'({2'b10, f3});
  endfunction

endpackage

// File: rtl/id_stage_imm_gen.sv
// Immediate generator: picks the I/S/B/U/J
// field and sign-extends bit 31 to XLEN.
module imm_gen
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] i32;

  // Select the format-specific 32-bit value
  always_comb begin
    i32 = '0;
    unique case (fmt)
      IMM_I: i32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S: i32 = {{20{instr[31]}},
                    instr[31:25], instr[11:7]};
      IMM_B: i32 = {{19{instr[31]}}, instr[31],
                    instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      IMM_U: i32 = {instr[31:12], 12'b0};
      IMM_J: i32 = {{11{instr[31]}}, instr[31],
                    instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      default: i32 = '0;
    endcase
  end

  // Sign-extend to the datapath width
  always_comb begin
    imm = {XLEN{i32[31]}};
    imm[31:0] = i32;
  end

endmodule

// File: rtl/id_stage.sv
// RV32I/RV64I decode stage with output register.
// Optional M extension: define RV_M_EXT_EN.
module id_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      alu_op,
  output logic            is_word,
  output logic            reg_write_enable,
  output logic            mem_read,
  output logic            mem_write,
  output logic            is_branch,
  output logic            jump,
  output logic            alu_src_imm,
  output logic            alu_src_pc,
  output logic            illegal
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      f_rd;
  logic [4:0]      f_rs1;
  logic [4:0]      f_rs2;
  id_ex_t          d;
  id_ex_t          q;
  imm_fmt_e        fmt;
  logic            ill;
  logic [XLEN-1:0] d_imm;
  logic [XLEN-1:0] q_imm;
  logic [XLEN-1:0] q_pc;
  logic            q_valid;
  logic            take;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign f_rd  = in_instr[11:7];
  assign f_rs1 = in_instr[19:15];
  assign f_rs2 = in_instr[24:20];

  // Flush always drains the input side
  assign in_ready = flush || !q_valid || out_ready;
  assign take     = in_valid && in_ready;

  // Opcode/funct decode into the ID->EX bundle
  always_comb begin
    d        = '0;
    d.alu_op = ALU_ADD;
    d.funct3 = f3;
    fmt      = IMM_NONE;
    ill      = 1'b0;
    unique case (1'b1)
      (in_instr[1:0] != 2'b11): ill = 1'b1;
      (opc == OPC_LOAD): begin
        d.rd  = f_rd;
        d.rs1 = f_rs1;
        fmt   = IMM_I;
        d.mem_read         = 1'b1;
        d.reg_write_enable = 1'b1;
        d.alu_src_imm      = 1'b1;
        ill = (f3 == 3'b111) ||
              (!RV64 && (f3 == 3'b011 ||
                         f3 == 3'b110));
      end
      (opc == OPC_STORE): begin
        d.rs1 = f_rs1;
        d.rs2 = f_rs2;
        fmt   = IMM_S;
        d.mem_write   = 1'b1;
        d.alu_src_imm = 1'b1;
        ill = f3[2] || (!RV64 && f3 == 3'b011);
      end
      (opc == OPC_BRANCH): begin
        d.rs1 = f_rs1;
        d.rs2 = f_rs2;
        fmt   = IMM_B;
        d.alu_op    = ALU_SUB;
        d.is_branch = 1'b1;
        ill = (f3 == 3'b010) || (f3 == 3'b011);
      end
      (opc == OPC_JAL): begin
        d.rd  = f_rd;
        fmt   = IMM_J;
        d.jump             = 1'b1;
        d.reg_write_enable = 1'b1;
        d.alu_src_imm      = 1'b1;
        d.alu_src_pc       = 1'b1;
      end
      (opc == OPC_JALR): begin
        d.rd  = f_rd;
        d.rs1 = f_rs1;
        fmt   = IMM_I;
        d.jump             = 1'b1;
        d.reg_write_enable = 1'b1;
        d.alu_src_imm      = 1'b1;
        ill = (f3 != 3'b000);
      end
      (opc == OPC_LUI): begin
        d.rd  = f_rd;
        fmt   = IMM_U;
        d.alu_op           = ALU_PASS_B;
        d.reg_write_enable = 1'b1;
        d.alu_src_imm      = 1'b1;
      end
      (opc == OPC_AUIPC): begin
        d.rd  = f_rd;
        fmt   = IMM_U;
        d.reg_write_enable = 1'b1;
        d.alu_src_imm      = 1'b1;
        d.alu_src_pc       = 1'b1;
      end
      (opc == OPC_OP_IMM): begin
        d.rd  = f_rd;
        d.rs1 = f_rs1;
        fmt   = IMM_I;
        d.reg_write_enable = 1'b1;
        d.alu_src_imm      = 1'b1;
        d.alu_op = base_alu(f3,
          in_instr[30] && f3 == 3'b101);
        if (f3 == 3'b001)
          ill = RV64 ? (in_instr[31:26] != 6'd0)
                     : (f7 != 7'd0);
        else if (f3 == 3'b101)
          ill = RV64
            ? (in_instr[31:26] != 6'b000000 &&
               in_instr[31:26] != 6'b010000)
            : (f7 != 7'b0000000 &&
               f7 != 7'b0100000);
      end
      (opc == OPC_OP): begin
        d.rd  = f_rd;
        d.rs1 = f_rs1;
        d.rs2 = f_rs2;
        d.reg_write_enable = 1'b1;
        if (f7 == 7'b0000000)
          d.alu_op = base_alu(f3, 1'b0);
        else if (f7 == 7'b0100000 &&
                 (f3 == 3'b000 || f3 == 3'b101))
          d.alu_op = base_alu(f3, 1'b1);
`ifdef RV_M_EXT_EN
        else if (f7 == 7'b0000001)
          d.alu_op = m_alu(f3);
`endif
        else
          ill = 1'b1;
      end
      (opc == OPC_OP_IMM_32): begin
        d.rd  = f_rd;
        d.rs1 = f_rs1;
        fmt   = IMM_I;
        d.is_word          = 1'b1;
        d.reg_write_enable = 1'b1;
        d.alu_src_imm      = 1'b1;
        d.alu_op = base_alu(f3,
          in_instr[30] && f3 == 3'b101);
        if (!RV64)
          ill = 1'b1;
        else if (f3 == 3'b001)
          ill = (f7 != 7'd0);
        else if (f3 == 3'b101)
          ill = (f7 != 7'b0000000 &&
                 f7 != 7'b0100000);
        else
          ill = (f3 != 3'b000);
      end
      (opc == OPC_OP_32): begin
        d.rd  = f_rd;
        d.rs1 = f_rs1;
        d.rs2 = f_rs2;
        d.is_word          = 1'b1;
        d.reg_write_enable = 1'b1;
        if (!RV64)
          ill = 1'b1;
        else if (f7 == 7'b0000000 &&
                 (f3 == 3'b000 || f3 == 3'b001 ||
                  f3 == 3'b101))
          d.alu_op = base_alu(f3, 1'b0);
        else if (f7 == 7'b0100000 &&
                 (f3 == 3'b000 || f3 == 3'b101))
          d.alu_op = base_alu(f3, 1'b1);
`ifdef RV_M_EXT_EN
        else if (f7 == 7'b0000001 &&
                 (f3 == 3'b000 || f3[2]))
          d.alu_op = m_alu(f3);
`endif
        else
          ill = 1'b1;
      end
      (opc == OPC_SYSTEM): ill = 1'b1;
      default: ill = 1'b1;
    endcase
    // Illegal: drop all side effects, let EX trap
    if (ill) begin
      d         = '0;
      d.alu_op  = ALU_ADD;
      d.funct3  = f3;
      d.illegal = 1'b1;
      fmt       = IMM_NONE;
    end
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr),
    .fmt   (fmt),
    .imm   (d_imm)
  );

  // Output register with valid/ready handshake
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_valid <= 1'b0;
      q       <= '0;
      q_imm   <= '0;
      q_pc    <= '0;
    end else if (flush) begin
      q_valid <= 1'b0;
    end else if (take) begin
      q_valid <= 1'b1;
      q       <= d;
      q_imm   <= d_imm;
      q_pc    <= in_pc;
    end else if (out_ready) begin
      q_valid <= 1'b0;
    end
  end

  assign out_valid        = q_valid;
  assign out_pc           = q_pc;
  assign imm              = q_imm;
  assign rd               = q.rd;
  assign rs1              = q.rs1;
  assign rs2              = q.rs2;
  assign funct3           = q.funct3;
  assign alu_op           = q.alu_op;
  assign is_word          = q.is_word;
  assign reg_write_enable = q.reg_write_enable;
  assign mem_read         = q.mem_read;
  assign mem_write        = q.mem_write;
  assign is_branch        = q.is_branch;
  assign jump             = q.jump;
  assign alu_src_imm      = q.alu_src_imm;
  assign alu_src_pc       = q.alu_src_pc;
  assign illegal          = q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: XLEN=64 and
// XLEN=32 instances fed the same stream.
module tb_id_stage;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic        out_ready;

  logic        rdy64, v64, w64, rwe64, mr64, mw64;
  logic        br64, j64, si64, sp64, ill64;
  logic [63:0] pc64, imm64;
  logic [4:0]  rd64, rs1_64, rs2_64, alu64;
  logic [2:0]  f3_64;

  logic        rdy32, v32, w32, rwe32, mr32, mw32;
  logic        br32, j32, si32, sp32, ill32;
  logic [31:0] pc32, imm32;
  logic [4:0]  rd32, rs1_32, rs2_32, alu32;
  logic [2:0]  f3_32;

  int n_tests;
  int n_fail;

  id_stage #(.XLEN(64)) dut64 (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64),
    .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(v64), .out_ready(out_ready),
    .out_pc(pc64), .rd(rd64), .rs1(rs1_64),
    .rs2(rs2_64), .funct3(f3_64), .imm(imm64),
    .alu_op(alu64), .is_word(w64),
    .reg_write_enable(rwe64), .mem_read(mr64),
    .mem_write(mw64), .is_branch(br64),
    .jump(j64), .alu_src_imm(si64),
    .alu_src_pc(sp64), .illegal(ill64)
  );

  id_stage #(.XLEN(32)) dut32 (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32),
    .in_pc(in_pc[31:0]), .in_instr(in_instr),
    .out_valid(v32), .out_ready(out_ready),
    .out_pc(pc32), .rd(rd32), .rs1(rs1_32),
    .rs2(rs2_32), .funct3(f3_32), .imm(imm32),
    .alu_op(alu32), .is_word(w32),
    .reg_write_enable(rwe32), .mem_read(mr32),
    .mem_write(mw32), .is_branch(br32),
    .jump(j32), .alu_src_imm(si32),
    .alu_src_pc(sp32), .illegal(ill32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic [31:0] ins,
    input logic [63:0] pc
  );
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    step();
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    resetn    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    out_ready = 1'b1;
    repeat (2) step();

    check("rst_valid", 64'(v64), 0);
    check("rst_pc", pc64, 0);
    check("rst_imm", imm64, 0);
    check("rst_rd", 64'(rd64), 0);
    check("rst_alu", 64'(alu64), 0);
    check("rst_rwe", 64'(rwe64), 0);
    check("rst_ill", 64'(ill64), 0);
    check("rst_rdy", 64'(rdy64), 1);
    resetn = 1'b1;
    step();

    // ADDI x5,x0,-1
    drive(32'hFFF00293, 64'h1000);
    check("addi_valid", 64'(v64), 1);
    check("addi_pc", pc64, 64'h1000);
    check("addi_rd", 64'(rd64), 5);
    check("addi_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_alu", 64'(alu64), 0);
    check("addi_rwe", 64'(rwe64), 1);
    check("addi_si", 64'(si64), 1);
    check("addi_imm32", 64'(imm32), 64'hFFFF_FFFF);

    // BEQ x0,x0,-4
    drive(32'hFE000EE3, 64'h1004);
    check("beq_valid", 64'(v64), 1);
    check("beq_br", 64'(br64), 1);
    check("beq_alu", 64'(alu64), 1);
    check("beq_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    check("beq_rwe", 64'(rwe64), 0);
    check("beq_rd", 64'(rd64), 0);

    // SW x5,8(x2)
    drive(32'h00512423, 64'h1008);
    check("sw_mw", 64'(mw64), 1);
    check("sw_rwe", 64'(rwe64), 0);
    check("sw_imm", imm64, 8);
    check("sw_rs1", 64'(rs1_64), 2);
    check("sw_rs2", 64'(rs2_64), 5);
    check("sw_rd", 64'(rd64), 0);
    check("sw_f3", 64'(f3_64), 2);

    // JAL x1,+8
    drive(32'h008000EF, 64'h100C);
    check("jal_j", 64'(j64), 1);
    check("jal_rwe", 64'(rwe64), 1);
    check("jal_sp", 64'(sp64), 1);
    check("jal_imm", imm64, 8);
    check("jal_rd", 64'(rd64), 1);

    // LUI x7,0x12345
    drive(32'h123453B7, 64'h1010);
    check("lui_alu", 64'(alu64), 10);
    check("lui_imm", imm64, 64'h1234_5000);
    check("lui_rd", 64'(rd64), 7);
    check("lui_rs1", 64'(rs1_64), 0);

    // SRAI x1,x1,32: RV64 only
    drive(32'h4200D093, 64'h1014);
    check("srai64_alu", 64'(alu64), 7);
    check("srai64_ill", 64'(ill64), 0);
    check("srai32_ill", 64'(ill32), 1);
    check("srai32_rwe", 64'(rwe32), 0);

    // ADDIW a0,x0,1
    drive(32'h0010051B, 64'h1018);
    check("addiw64_w", 64'(w64), 1);
    check("addiw64_imm", imm64, 1);
    check("addiw64_ill", 64'(ill64), 0);
    check("addiw64_rd", 64'(rd64), 10);
    check("addiw32_ill", 64'(ill32), 1);
    check("addiw32_w", 64'(w32), 0);
    check("addiw32_valid", 64'(v32), 1);

    // MUL a0,a1,a2
    drive(32'h02C58533, 64'h101C);
`ifdef RV_M_EXT_EN
    check("mul_alu", 64'(alu64), 16);
    check("mul_ill", 64'(ill64), 0);
    check("mul_rwe", 64'(rwe64), 1);
`else
    check("mul_ill", 64'(ill64), 1);
    check("mul_rwe", 64'(rwe64), 0);
`endif

    // Compressed-space word and ECALL
    drive(32'h00000000, 64'h1020);
    check("c0_ill", 64'(ill64), 1);
    check("c0_valid", 64'(v64), 1);
    drive(32'h00000073, 64'h1024);
    check("ecall_ill", 64'(ill64), 1);
    check("ecall_rwe", 64'(rwe64), 0);

    // Drain with no new input
    in_valid = 1'b0;
    step();
    check("drain_valid", 64'(v64), 0);

    // Back-pressure: 3 ADDIs, 3 stall cycles
    out_ready = 1'b0;
    drive(32'h00100093, 64'h2000);
    check("bp1_rd", 64'(rd64), 1);
    in_instr = 32'h00200113;
    in_pc    = 64'h2004;
    #1;
    check("bp_rdy", 64'(rdy64), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_v", 64'(v64), 1);
      check("bp_hold_rd", 64'(rd64), 1);
      check("bp_hold_pc", pc64, 64'h2000);
    end
    out_ready = 1'b1;
    step();
    check("bp2_rd", 64'(rd64), 2);
    check("bp2_imm", imm64, 2);
    drive(32'h00300193, 64'h2008);
    check("bp3_rd", 64'(rd64), 3);
    check("bp3_pc", pc64, 64'h2008);

    // Flush with held and incoming instructions
    out_ready = 1'b0;
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h123453B7;
    in_pc     = 64'h3000;
    #1;
    check("fl_rdy", 64'(rdy64), 1);
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("fl_valid", 64'(v64), 0);
    step();
    check("fl_valid2", 64'(v64), 0);
    check("fl_pc", pc64, 64'h2008);

    // Async reset during a stall
    out_ready = 1'b0;
    drive(32'h00100093, 64'h4000);
    in_valid = 1'b0;
    check("ar_pre", 64'(v64), 1);
    #2;
    resetn = 1'b0;
    #1;
    check("ar_valid", 64'(v64), 0);
    check("ar_rd", 64'(rd64), 0);
    #2;
    resetn = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Parametrised RV32I/RV64I instruction-decode pipeline stage that sits between fetch and execute. It decodes each 32-bit instruction into register indices, a sign-extended immediate, an ALU operation and control flags. It holds the result in an output register guarded by a valid/ready handshake, so back-pressure from execute stalls fetch without losing instructions. It adds what the first-generation decoder lacked: full immediate generation, an ALU operation map, illegal-instruction detection, RV64 word operations and flow control.

## Interface
- XLEN, 64, datapath width; legal values 32 or 64.
- clk  in  1  clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous kill of the held instruction and of the incoming one.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_pc  in  XLEN  PC of the instruction.
- in_instr  in  32  raw instruction.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_pc  out  XLEN  forwarded PC.
- rd / rs1 / rs2  out  5 each  register indices; zeroed when unused by the format.
- funct3  out  3  forwarded funct3.
- imm  out  XLEN  sign-extended immediate (I/S/B/U/J).
- alu_op  out  5  ALU operation code.
- is_word  out  1  RV64 32-bit op (OP-32 / OP-IMM-32).
- reg_write_enable, mem_read, mem_write, is_branch, jump, alu_src_imm, alu_src_pc  out  1 each  control flags.
- illegal  out  1  instruction is not decodable.

## Operation
- Handshake: in_ready = !out_valid || out_ready. A transfer occurs when in_valid && in_ready; the decoded bundle loads into the output register and out_valid is set to 1.
- If out_valid && out_ready && !(in_valid && in_ready), out_valid is cleared to 0.
- When out_valid && !out_ready, every output holds its value.
- Flush has priority over everything: out_valid is cleared to 0, and an instruction presented in the same cycle is consumed and discarded (in_ready = 1 during flush).
- alu_op codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASS_B 10; MUL 16, MULH 17, MULHSU 18, MULHU 19, DIV 20, DIVU 21, REM 22, REMU 23.
- Opcode mapping:
  - Loads, stores, JAL, JALR and AUIPC use ADD.
  - LUI uses PASS_B.
  - Branches use SUB with is_branch=1.
  - JAL/JALR set jump=1 and reg_write_enable=1.
  - AUIPC and JAL set alu_src_pc=1.
- Immediates:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All sign-extended from bit 31 to XLEN.
- Shift immediates: shamt is 6 bits when XLEN=64 and 5 bits when XLEN=32. For XLEN=32, instr[25]=1 on a shift is illegal.
- OP-32 / OP-IMM-32 are decoded with is_word=1 only when XLEN=64; otherwise they are illegal.
- illegal=1 for any of: instr[1:0] != 2'b11, an unknown opcode, a funct7/funct3 combination outside the base set, or ECALL/EBREAK/CSR (SYSTEM is not decoded by this stage).
  - When illegal=1, all write/memory/branch/jump flags are 0.
  - out_valid still asserts, so the downstream stage raises the trap.
- Reset values: out_valid 0, out_pc 0, imm 0, all indices 0, alu_op ADD, all flags 0, illegal 0.

## Timing
- Latency is 1 cycle from accepted input to out_valid. Throughput is 1 instruction per cycle when out_ready is held at 1.
- in_ready is combinational from out_valid and out_ready. No other output depends combinationally on inputs.
- Reset asserted mid-stall clears out_valid immediately (asynchronously); the held instruction is lost.
- Simultaneous drain and load (out_valid && out_ready && in_valid) replaces the bundle with no bubble.

## Configuration
- RV_M_EXT_EN defined: OP (and OP-32 when XLEN=64) with funct7=0000001 decodes to MUL..REMU (codes 16–23) with reg_write_enable=1.
- RV_M_EXT_EN undefined: those encodings set illegal=1.

## Structure
- Package rv_decode_pkg holds:
  - opcode localparams (LOAD, STORE, OP, OP_IMM, OP_32, OP_IMM_32, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM);
  - the alu_op_e enum (5-bit);
  - the imm_fmt_e enum (I, S, B, U, J, NONE);
  - the decoded-bundle packed struct.
- One combinational sub-module, imm_gen (instr, imm_fmt_e → XLEN-bit imm). The remaining decode logic plus the output register live in id_stage.

## Test plan
- ADDI x5,x0,-1 (0xFFF00293), XLEN=64 → next cycle out_valid=1, rd=5, imm=0xFFFF_FFFF_FFFF_FFFF, alu_op=0, reg_write_enable=1, alu_src_imm=1.
- BEQ with 0xFE000EE3 → is_branch=1, alu_op=1, imm=-4 sign-extended, reg_write_enable=0.
- Back-pressure: three back-to-back valid instructions with out_ready=0 for 3 cycles → in_ready=0, first bundle held unchanged; after release, three bundles emerge in order with no loss.
- Flush asserted while out_valid=1 and in_valid=1 → next cycle out_valid=0, neither instruction ever appears.
- 0x02C5_8533 (MUL a0,a1,a2) → alu_op=16 with RV_M_EXT_EN defined, illegal=1 without it.
- ADDIW 0x0010051B with XLEN=32 → illegal=1, is_word=0; with XLEN=64 → is_word=1, imm=1.
